// File: rtl/pipelined_addsub_pkg.sv
// addsub_pkg: shared op/flag types and slice sizing for pipelined_addsub
package addsub_pkg;
  typedef enum logic {OP_ADD, OP_SUB} addsub_op_t;
  typedef struct packed {
    logic cout;
    logic ovf;
    logic zero;
    logic neg;
    logic sat;
  } addsub_flags_t;
  function automatic int slice_width(int width, int stages);
    return (width + stages - 1) / stages;
  endfunction
endpackage

// File: rtl/pipelined_addsub_if.sv
// pipelined_addsub_if: operand/result valid-ready bus of the pipelined adder/subtractor
interface pipelined_addsub_if #(parameter int WIDTH = 9);
  logic             in_valid, in_ready, sub, signed_md;
  logic             out_valid, out_ready, cout, ovf, zero, neg, sat;
  logic [WIDTH-1:0] a, b, sum;
  modport master (output in_valid, a, b, sub, signed_md, out_ready,
                  input  in_ready, out_valid, sum, cout, ovf, zero, neg, sat);
  modport slave  (input  in_valid, a, b, sub, signed_md, out_ready,
                  output in_ready, out_valid, sum, cout, ovf, zero, neg, sat);
endinterface

// File: rtl/pipelined_addsub_slice.sv
// addsub_slice: combinational CW-bit add of one carry-chain slice with carry in/out
module addsub_slice #(parameter int CW = 3) (
  input  logic [CW-1:0] i_a,
  input  logic [CW-1:0] i_b,
  input  logic          i_cin,
  output logic [CW-1:0] o_sum,
  output logic          o_cout
);
  assign {o_cout, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {{CW{1'b0}}, i_cin};
endmodule

// File: rtl/pipelined_addsub.sv
// pipelined_addsub: STAGES-deep sliced adder/subtractor with valid/ready and flags; optional clamp via PIPELINED_ADDSUB_SATURATE_EN
module pipelined_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH  = 9,
  parameter int STAGES = 3
) (
  input logic              clk,
  input logic              reset_n,
  pipelined_addsub_if.slave bus
);
  localparam int CW = slice_width(WIDTH, STAGES);
  localparam int L  = STAGES - 1;
  logic             w_adv;
  logic [WIDTH-1:0] w_a [STAGES];
  logic [WIDTH-1:0] w_b [STAGES];
  logic [WIDTH-1:0] w_s [STAGES];
  logic [WIDTH-1:0] w_so [STAGES];
  logic             w_c [STAGES];
  logic             w_co [STAGES];
  logic             w_v [STAGES];
  logic             w_sm [STAGES];
  addsub_op_t       w_op [STAGES];
  logic [WIDTH-1:0] w_fin;
  logic             w_ovf, w_sat, w_am;
  logic [WIDTH-1:0] r_sum;
  addsub_flags_t    r_flags;
  logic             r_ov;
  // the whole pipe moves together; it only freezes when a result is waiting
  assign w_adv        = !r_ov || bus.out_ready;
  assign bus.in_ready = w_adv;
  assign w_op[0] = bus.sub ? OP_SUB : OP_ADD;
  assign w_a[0]  = bus.a;
  assign w_b[0]  = bus.sub ? ~bus.b : bus.b;
  assign w_s[0]  = '0;
  assign w_c[0]  = bus.sub;
  assign w_v[0]  = bus.in_valid;
  assign w_sm[0] = bus.signed_md;
  for (genvar k = 0; k < STAGES; k++) begin : g_st
    localparam int LO = k * CW;
    localparam int SW = ((WIDTH - LO) < CW) ? (WIDTH - LO) : CW;
    if (SW > 0) begin : g_add
      localparam logic [WIDTH-1:0] M = ({WIDTH{1'b1}} >> (WIDTH - SW)) << LO;
      logic [SW-1:0] w_sl;
      addsub_slice #(.CW(SW)) u_slice (
        .i_a   (w_a[k][LO +: SW]),
        .i_b   (w_b[k][LO +: SW]),
        .i_cin (w_c[k]),
        .o_sum (w_sl),
        .o_cout(w_co[k])
      );
      assign w_so[k] = (w_s[k] & ~M) | (WIDTH'(w_sl) << LO);
    end else begin : g_pass
      // ceil sizing can leave trailing slices empty; they just forward the carry
      assign w_so[k] = w_s[k];
      assign w_co[k] = w_c[k];
    end
    if (k < L) begin : g_reg
      logic [WIDTH-1:0] r_a, r_b, r_s;
      logic             r_c, r_v, r_sm;
      addsub_op_t       r_op;
      // carry the operands, partial sum and slice carry into the next stage; only valid needs reset
      always_ff @(posedge clk)
        if (!reset_n) r_v <= 1'b0;
        else if (w_adv) begin
          r_a  <= w_a[k];
          r_b  <= w_b[k];
          r_s  <= w_so[k];
          r_c  <= w_co[k];
          r_v  <= w_v[k];
          r_sm <= w_sm[k];
          r_op <= w_op[k];
        end
      assign w_a[k+1]  = r_a;
      assign w_b[k+1]  = r_b;
      assign w_s[k+1]  = r_s;
      assign w_c[k+1]  = r_c;
      assign w_v[k+1]  = r_v;
      assign w_sm[k+1] = r_sm;
      assign w_op[k+1] = r_op;
    end
  end
  assign w_am  = w_a[L][WIDTH-1];
  assign w_ovf = (w_am == w_b[L][WIDTH-1]) && (w_so[L][WIDTH-1] != w_am);
`ifdef PIPELINED_ADDSUB_SATURATE_EN
  logic w_clamp_s, w_clamp_u;
  assign w_clamp_s = w_sm[L] && w_ovf;
  assign w_clamp_u = !w_sm[L] && ((w_op[L] == OP_SUB) ? !w_co[L] : w_co[L]);
  assign w_sat     = w_clamp_s || w_clamp_u;
  assign w_fin     = w_clamp_s ? {w_am, {(WIDTH-1){!w_am}}} :
                     w_clamp_u ? {WIDTH{w_op[L] == OP_ADD}} : w_so[L];
`else
  logic [1:0] w_unused;
  assign w_unused = {w_sm[L], w_op[L] == OP_SUB};
  assign w_sat    = 1'b0;
  assign w_fin    = w_so[L];
`endif
  // output register: final result and flags, held while downstream stalls
  always_ff @(posedge clk)
    if (!reset_n) begin
      r_ov    <= 1'b0;
      r_sum   <= '0;
      r_flags <= '0;
    end else if (w_adv) begin
      r_ov    <= w_v[L];
      r_sum   <= w_fin;
      r_flags <= {w_co[L], w_ovf, w_fin == '0, w_fin[WIDTH-1], w_sat};
    end
  assign bus.out_valid = r_ov;
  assign bus.sum       = r_sum;
  assign bus.cout      = r_flags.cout;
  assign bus.ovf       = r_flags.ovf;
  assign bus.zero      = r_flags.zero;
  assign bus.neg       = r_flags.neg;
  assign bus.sat       = r_flags.sat;
endmodule

// File: tb/tb_pipelined_addsub.sv
// tb_pipelined_addsub: random and directed checks of pipelined_addsub at STAGES 3, 1 and 9 against an arithmetic model
module tb_pipelined_addsub;
  localparam int W = 9;
  typedef struct {
    logic [W+4:0] r;
    int           t;
    int           s;
  } exp_t;
  logic         clk = 0, reset_n = 0;
  logic         in_valid = 0, sub = 0, sm = 0, out_ready = 1;
  logic [W-1:0] a = '0, b = '0;
  logic         rdy0, ov0;
  logic [W+4:0] res0;
  int           n_chk = 0, n_err = 0;
  int           pending [3];
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // result = {sum, cout, ovf, zero, neg, sat} from plain integer arithmetic
  function automatic logic [W+4:0] model(input logic [W-1:0] ma, mb, input logic ms, msm);
    int ua, ub, sa, sb, sr;
    logic [W-1:0] r;
    logic c, o, st;
    ua = int'(ma);
    ub = int'(mb);
    sa = (ua >= (1 << (W-1))) ? ua - (1 << W) : ua;
    sb = (ub >= (1 << (W-1))) ? ub - (1 << W) : ub;
    c  = ms ? (ua >= ub) : (ua + ub >= (1 << W));
    sr = ms ? sa - sb : sa + sb;
    o  = (sr > (1 << (W-1)) - 1) || (sr < -(1 << (W-1)));
    r  = W'((ms ? ua - ub : ua + ub) & ((1 << W) - 1));
    st = 1'b0;
`ifdef PIPELINED_ADDSUB_SATURATE_EN
    if (msm && o) begin
      r  = (sr > 0) ? W'((1 << (W-1)) - 1) : W'(1 << (W-1));
      st = 1'b1;
    end else if (!msm && (ms ? !c : c)) begin
      r  = ms ? '0 : '1;
      st = 1'b1;
    end
`endif
    return {r, c, o, r == '0, r[W-1], st};
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int L = (g == 0) ? 3 : (g == 1) ? 1 : 9;
    pipelined_addsub_if #(.WIDTH(W)) bus ();
    pipelined_addsub #(.WIDTH(W), .STAGES(L)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
    assign bus.in_valid  = in_valid;
    assign bus.a         = a;
    assign bus.b         = b;
    assign bus.sub       = sub;
    assign bus.signed_md = sm;
    assign bus.out_ready = out_ready;
    if (g == 0) begin : g_tap
      assign rdy0 = bus.in_ready;
      assign ov0  = bus.out_valid;
      assign res0 = {bus.sum, bus.cout, bus.ovf, bus.zero, bus.neg, bus.sat};
    end
    exp_t         q [$];
    int           cyc = 0, stalls = 0;
    logic         was_rst = 0, was_stall = 0;
    logic [W+5:0] held = '0;
    // scoreboard: accepted beats must leave in order, with the model's value, after L cycles plus stall cycles
    always @(negedge clk) begin
      logic [W+5:0] cur;
      exp_t         e;
      cur = {bus.out_valid, bus.sum, bus.cout, bus.ovf, bus.zero, bus.neg, bus.sat};
      if (was_rst) check($sformatf("L%0d_reset_out", L), 64'(cur), 64'(0));
      if (was_stall) check($sformatf("L%0d_stall_hold", L), 64'(cur), 64'(held));
      was_rst   = !reset_n;
      was_stall = 1'b0;
      if (!reset_n) q.delete();
      else begin
        check($sformatf("L%0d_in_ready", L), 64'(bus.in_ready), 64'(!bus.out_valid || out_ready));
        if (bus.out_valid && out_ready) begin
          check($sformatf("L%0d_beat_expected", L), 64'(q.size() != 0), 64'(1));
          if (q.size() != 0) begin
            e = q.pop_front();
            check($sformatf("L%0d_result", L), 64'(cur[W+4:0]), 64'(e.r));
            check($sformatf("L%0d_latency", L), 64'(cyc - e.t), 64'(L + stalls - e.s));
          end
        end
        if (in_valid && bus.in_ready) q.push_back('{model(a, b, sub, sm), cyc, stalls});
        if (bus.out_valid && !out_ready) begin
          stalls++;
          was_stall = 1'b1;
          held      = cur;
        end
      end
      cyc++;
      pending[g] = q.size();
    end
  end

  task automatic send(input logic [W-1:0] ta, tb_, input logic ts, tsm);
    int n = 0;
    a = ta; b = tb_; sub = ts; sm = tsm; in_valid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!rdy0 && n < 50);
    check("accept", 64'(rdy0), 64'(1));
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ov0 && n < 30);
    check("out_timeout", 64'(ov0), 64'(1));
  endtask

  task automatic dir_chk(input logic [W-1:0] ta, tb_, input logic ts, tsm, input logic [W+4:0] exp);
    int n;
    send(ta, tb_, ts, tsm);
    wait_out(n);
    check($sformatf("dir_%0d_%0d_%0d", ta, tb_, ts), 64'(res0), 64'(exp));
    check("dir_latency", 64'(n), 64'(3));
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] pick();
    int unsigned r;
    r = $urandom_range(0, 7);
    return (r == 0) ? '0 : (r == 1) ? W'(255) : (r == 2) ? W'(256) : (r == 3) ? '1 : W'($urandom);
  endfunction

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int  n;
    logic rnd;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    check("reset_in_ready", 64'(rdy0), 64'(1));
    check("reset_outputs", 64'({ov0, res0}), 64'(0));
    @(posedge clk);
    #1;
    dir_chk(9'd0, 9'd341, 1'b0, 1'b0, {9'd341, 5'b00010});
    dir_chk(9'd5, 9'd507, 1'b0, 1'b1, {9'd0, 5'b10100});
    dir_chk(9'd511, 9'd1, 1'b0, 1'b1, {9'd0, 5'b10100});
`ifdef PIPELINED_ADDSUB_SATURATE_EN
    dir_chk(9'd255, 9'd1, 1'b0, 1'b1, {9'd255, 5'b01001});
    dir_chk(9'd256, 9'd511, 1'b0, 1'b1, {9'd256, 5'b11011});
    dir_chk(9'd3, 9'd5, 1'b1, 1'b0, {9'd0, 5'b00101});
`else
    dir_chk(9'd255, 9'd1, 1'b0, 1'b1, {9'd256, 5'b01010});
    dir_chk(9'd256, 9'd511, 1'b0, 1'b1, {9'd255, 5'b11000});
    dir_chk(9'd3, 9'd5, 1'b1, 1'b0, {9'd510, 5'b00010});
`endif
    fork
      for (int i = 0; i < 8; i++) send(pick(), pick(), 1'($urandom), 1'($urandom));
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (4) begin
          @(negedge clk);
          check("stall_out_valid", 64'(ov0), 64'(1));
          check("stall_in_ready", 64'(rdy0), 64'(0));
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    repeat (12) @(posedge clk);
    #1;
    send(9'd10, 9'd20, 1'b0, 1'b0);
    send(9'd30, 9'd40, 1'b1, 1'b1);
    reset_n = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    check("mid_reset_outputs", 64'({ov0, res0}), 64'(0));
    @(posedge clk);
    #1;
    send(9'd100, 9'd27, 1'b1, 1'b0);
    wait_out(n);
    check("post_reset_latency", 64'(n), 64'(3));
    check("post_reset_result", 64'(res0), 64'({9'd73, 5'b10000}));
    @(posedge clk);
    #1;
    rnd = 1'b1;
    fork
      begin
        for (int i = 0; i < 120; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
          send(pick(), pick(), 1'($urandom), 1'($urandom));
        end
        rnd = 1'b0;
      end
      while (rnd) begin
        @(posedge clk);
        #1 out_ready = ($urandom_range(0, 3) != 0);
      end
    join
    out_ready = 1'b1;
    repeat (15) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) check($sformatf("drained_%0d", i), 64'(pending[i]), 64'(0));
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
